// File: rtl/change_dispenser.sv
// Change payout engine: turns a cents amount into a greedy sequence of
// dollar/quarter/dime/nickel eject pulses while tracking coin inventory.
module change_dispenser #(
  parameter int unsigned AMT_W        = 10,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned INIT_COUNT   = 8,
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             refill,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] short_amt,
  output logic             eject_dollar,
  output logic             eject_quarter,
  output logic             eject_dime,
  output logic             eject_nickel,
  output logic [CNT_W-1:0] cnt_dollar,
  output logic [CNT_W-1:0] cnt_quarter,
  output logic [CNT_W-1:0] cnt_dime,
  output logic [CNT_W-1:0] cnt_nickel
);

  localparam int unsigned N_DEN   = 4;
  localparam int unsigned TMR_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_e;

  // Index 0 is the largest coin; the select scan relies on that ordering.
  function automatic logic [AMT_W-1:0] denom_val(input logic [1:0] idx);
    case (idx)
      2'd0:    return AMT_W'(100);
      2'd1:    return AMT_W'(25);
      2'd2:    return AMT_W'(10);
      default: return AMT_W'(5);
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [AMT_W-1:0] short_q, short_d;
  logic [CNT_W-1:0] cnt_q [N_DEN];
  logic [CNT_W-1:0] cnt_d [N_DEN];
  logic [N_DEN-1:0] eject_q, eject_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             found;
  logic [1:0]       sel;

  // Largest affordable coin still in stock; later (smaller-index) hits override.
  always_comb begin
    found = 1'b0;
    sel   = 2'd0;
    for (int i = N_DEN - 1; i >= 0; i--) begin
      if ((cnt_q[i] != '0) && (rem_q >= denom_val(2'(i)))) begin
        found = 1'b1;
        sel   = 2'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    rem_d   = rem_q;
    short_d = short_q;
    cnt_d   = cnt_q;
    eject_d = '0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = amount;
          state_d = S_SELECT;
        end else if (refill) begin
          for (int i = 0; i < N_DEN; i++) cnt_d[i] = CNT_W'(INIT_COUNT);
        end
      end
      S_SELECT: begin
        if (found) begin
          rem_d      = rem_q - denom_val(sel);
          cnt_d[sel] = cnt_q[sel] - CNT_W'(1);
          eject_d    = N_DEN'(1) << sel;
          tmr_d      = TMR_W'(PULSE_CYCLES - 1);
          state_d    = S_PULSE;
        end else begin
          short_d = rem_q;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_PULSE: begin
        if (tmr_q == '0) begin
          tmr_d   = TMR_W'(GAP_CYCLES - 1);
          state_d = S_GAP;
        end else begin
          tmr_d   = tmr_q - TMR_W'(1);
          eject_d = eject_q;
        end
      end
      S_GAP: begin
        if (tmr_q == '0) state_d = S_SELECT;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      rem_q   <= '0;
      short_q <= '0;
      eject_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < N_DEN; i++) cnt_q[i] <= CNT_W'(INIT_COUNT);
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      rem_q   <= rem_d;
      short_q <= short_d;
      eject_q <= eject_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign short_amt     = short_q;
  assign eject_dollar  = eject_q[0];
  assign eject_quarter = eject_q[1];
  assign eject_dime    = eject_q[2];
  assign eject_nickel  = eject_q[3];
  assign cnt_dollar    = cnt_q[0];
  assign cnt_quarter   = cnt_q[1];
  assign cnt_dime      = cnt_q[2];
  assign cnt_nickel    = cnt_q[3];

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: three instances (inventories 8, 2, 1) checked
// cycle by cycle against a greedy coin model with per-instance inventory.
module tb_change_dispenser;

  localparam int unsigned AW   = 10;
  localparam int unsigned CW   = 8;
  localparam int unsigned P    = 4;
  localparam int unsigned G    = 4;
  localparam int          COIN = 1 + P + G;
  localparam int          NI   = 3;

  logic          clk;
  logic          rst;
  logic          start  [NI];
  logic          refill [NI];
  logic [AW-1:0] amount [NI];
  logic          busy   [NI];
  logic          done   [NI];
  logic [AW-1:0] short_amt [NI];
  logic          ed [NI];
  logic          eq [NI];
  logic          ei [NI];
  logic          en [NI];
  logic [CW-1:0] cd [NI];
  logic [CW-1:0] cq [NI];
  logic [CW-1:0] ci [NI];
  logic [CW-1:0] cn [NI];

  int checks = 0;
  int errors = 0;
  int mcnt   [NI][4];
  int mshort [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    change_dispenser #(
      .AMT_W(AW), .CNT_W(CW),
      .INIT_COUNT((g == 0) ? 8 : (g == 1) ? 2 : 1),
      .PULSE_CYCLES(P), .GAP_CYCLES(G)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start[g]), .amount(amount[g]), .refill(refill[g]),
      .busy(busy[g]), .done(done[g]), .short_amt(short_amt[g]),
      .eject_dollar(ed[g]), .eject_quarter(eq[g]), .eject_dime(ei[g]), .eject_nickel(en[g]),
      .cnt_dollar(cd[g]), .cnt_quarter(cq[g]), .cnt_dime(ci[g]), .cnt_nickel(cn[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int init_of(input int inst);
    return (inst == 0) ? 8 : (inst == 1) ? 2 : 1;
  endfunction

  function automatic int coin_val(input int d);
    case (d)
      0:       return 100;
      1:       return 25;
      2:       return 10;
      default: return 5;
    endcase
  endfunction

  // Bit 3 = dollar ... bit 0 = nickel.
  function automatic logic [3:0] ejects(input int inst);
    return {ed[inst], eq[inst], ei[inst], en[inst]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int inst);
    chk($sformatf("idle_busy[%0d]", inst), 32'(busy[inst]), 0);
    chk($sformatf("idle_done[%0d]", inst), 32'(done[inst]), 0);
    chk($sformatf("idle_eject[%0d]", inst), 32'(ejects(inst)), 0);
    chk($sformatf("short[%0d]", inst), 32'(short_amt[inst]), 32'(mshort[inst]));
    chk($sformatf("cnt_dollar[%0d]", inst), 32'(cd[inst]), 32'(mcnt[inst][0]));
    chk($sformatf("cnt_quarter[%0d]", inst), 32'(cq[inst]), 32'(mcnt[inst][1]));
    chk($sformatf("cnt_dime[%0d]", inst), 32'(ci[inst]), 32'(mcnt[inst][2]));
    chk($sformatf("cnt_nickel[%0d]", inst), 32'(cn[inst]), 32'(mcnt[inst][3]));
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      mshort[i] = 0;
      for (int d = 0; d < 4; d++) mcnt[i][d] = init_of(i);
    end
  endtask

  task automatic do_refill(input int inst);
    @(negedge clk);
    refill[inst] = 1'b1;
    @(negedge clk);
    refill[inst] = 1'b0;
    for (int d = 0; d < 4; d++) mcnt[inst][d] = init_of(inst);
    check_idle(inst);
  endtask

  // Full payout; at cycle extra_t (if nonzero) a start+refill is pulsed that must be ignored.
  task automatic payout(input int inst, input int amt, input int extra_t);
    int coins[$];
    int rem;
    int tdone;
    logic [3:0] exp_ej;
    rem = amt;
    for (int d = 0; d < 4; d++) begin
      while (rem >= coin_val(d) && mcnt[inst][d] > 0) begin
        coins.push_back(d);
        rem -= coin_val(d);
        mcnt[inst][d]--;
      end
    end
    tdone = 2 + coins.size() * COIN;
    @(negedge clk);
    start[inst]  = 1'b1;
    amount[inst] = AW'(amt);
    for (int t = 1; t <= tdone; t++) begin
      @(negedge clk);
      start[inst]  = 1'b0;
      refill[inst] = 1'b0;
      amount[inst] = AW'($urandom_range(0, 1023));
      exp_ej = 4'b0000;
      if (t >= 2 && t < tdone && ((t - 2) % COIN) < P)
        exp_ej = 4'b1000 >> coins[(t - 2) / COIN];
      chk($sformatf("busy[%0d] amt=%0d t=%0d", inst, amt, t), 32'(busy[inst]), 1);
      chk($sformatf("done[%0d] amt=%0d t=%0d", inst, amt, t), 32'(done[inst]), 32'(t == tdone));
      chk($sformatf("eject[%0d] amt=%0d t=%0d", inst, amt, t), 32'(ejects(inst)), 32'(exp_ej));
      if (t == tdone)
        chk($sformatf("done_short[%0d] amt=%0d", inst, amt), 32'(short_amt[inst]), 32'(rem));
      if (t == extra_t) begin
        start[inst]  = 1'b1;
        refill[inst] = 1'b1;
      end
    end
    mshort[inst] = rem;
    @(negedge clk);
    start[inst]  = 1'b0;
    refill[inst] = 1'b0;
    check_idle(inst);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0; refill[i] = 1'b0; amount[i] = '0;
    end
    model_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) check_idle(i);
    rst = 1'b0;

    // Full greedy sequence, zero amount, tight inventory, exhaustion + refill.
    payout(0, 140, 0);
    payout(0, 0, 0);
    payout(1, 75, 0);
    payout(2, 200, 0);
    do_refill(2);

    // Odd residue; start/refill while busy must be dropped.
    payout(0, 7, 5);
    @(negedge clk);
    check_idle(0);

    // Reset in the second cycle of a dollar pulse.
    @(negedge clk);
    start[0] = 1'b1; amount[0] = AW'(150);
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    chk("rst_pulse_t2", 32'(ejects(0)), 32'(4'b1000));
    @(negedge clk);
    chk("rst_pulse_t3", 32'(ejects(0)), 32'(4'b1000));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < NI; i++) check_idle(i);
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      chk($sformatf("post_rst_done t=%0d", t), 32'(done[0]), 0);
      chk($sformatf("post_rst_busy t=%0d", t), 32'(busy[0]), 0);
    end

    // Random payouts across all inventories.
    for (int n = 0; n < 40; n++) begin
      int inst;
      inst = int'($urandom_range(0, NI - 1));
      if ($urandom_range(0, 3) == 0) do_refill(inst);
      payout(inst, int'($urandom_range(0, 400)),
             ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 10)) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
